// File: rtl/password_pkg.sv
// Shared types and sizes for the password setter/checker pair that both
// access the common 4-entry digit store.
package password_pkg;

   localparam int PASSWORD_LEN = 4;
   localparam int DIGIT_W      = 4;
   localparam int ADDR_W       = 2;
   localparam int FAIL_CNT_W   = 4;

   // Checker walks the store one digit index per accepted entry.
   typedef enum logic [2:0] {
      S_0 = 3'd0,
      S_1 = 3'd1,
      S_2 = 3'd2,
      S_3 = 3'd3
   } CheckState;

   // Writer-side sequencing, kept here so both sides share one definition.
   typedef enum logic [2:0] {
      SET_IDLE = 3'd0,
      SET_D0   = 3'd1,
      SET_D1   = 3'd2,
      SET_D2   = 3'd3,
      SET_D3   = 3'd4
   } SetState;

   function automatic CheckState next_check_state(input CheckState s);
      case (s)
         S_0:     return S_1;
         S_1:     return S_2;
         S_2:     return S_3;
         default: return S_0;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] check_addr(input CheckState s);
      return ADDR_W'(s);
   endfunction

endpackage

// File: rtl/lockout_counter.sv
// Consecutive-failure counter with a sticky alarm once MAX_FAILS is reached.
// masterClear (only driven when MASTER_CODE_EN is built) releases the lockout.
module lockout_counter
   import password_pkg::*;
#(
   parameter int MAX_FAILS = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  fail,
   input  logic                  success,
   input  logic                  masterClear,
   output logic [FAIL_CNT_W-1:0] failCount,
   output logic                  alarm
);

   localparam logic [FAIL_CNT_W-1:0] MAX_CNT = FAIL_CNT_W'(MAX_FAILS);

   logic [FAIL_CNT_W-1:0] r_count;
   logic                  r_alarm;
   logic [FAIL_CNT_W-1:0] w_count_sat;

   // Saturate so a failure at the limit cannot wrap the counter.
   assign w_count_sat = (r_count == MAX_CNT) ? r_count : r_count + 1'b1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count <= '0;
         r_alarm <= 1'b0;
      end else if (masterClear) begin
         r_count <= '0;
         r_alarm <= 1'b0;
      end else if (success) begin
         r_count <= '0;
      end else if (fail) begin
         r_count <= w_count_sat;
         if (w_count_sat == MAX_CNT) begin
            r_alarm <= 1'b1;
         end
      end
   end

   assign failCount = r_count;
   assign alarm     = r_alarm;

endmodule

// File: rtl/password_checker.sv
// Serial 4-digit password checker reading the shared store; optional master
// code override compiled in with `define MASTER_CODE_EN.
module password_checker
   import password_pkg::*;
#(
   parameter int                         MAX_FAILS   = 3,
   parameter logic [PASSWORD_LEN*4-1:0]  MASTER_CODE = 16'h9999
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DIGIT_W-1:0]    digit,
   output logic [ADDR_W-1:0]     readAddress,
   input  logic [DIGIT_W-1:0]    readData,
   output logic                  unlocked,
   output logic                  failed,
   output logic                  alarm,
   output logic [FAIL_CNT_W-1:0] failCount,
   output logic [2:0]            dbgState
);

   CheckState             r_state;
   logic                  r_mismatch;
   logic                  r_unlocked;
   logic                  r_failed;

   logic [ADDR_W-1:0]     w_addr;
   logic                  w_digit_mis;
   logic                  w_final_mis;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_success;
   logic                  w_fail;
   logic                  w_master_clear;
   logic                  w_alarm;
   logic [FAIL_CNT_W-1:0] w_fail_count;

   assign w_addr      = check_addr(r_state);
   assign w_digit_mis = (digit != readData);
   assign w_final_mis = r_mismatch | w_digit_mis;
   assign w_last      = w_accept && (r_state == CheckState'(PASSWORD_LEN - 1));

`ifdef MASTER_CODE_EN
   logic                 r_master_mis;
   logic [DIGIT_W-1:0]   w_master_digit;
   logic                 w_master_final;

   assign w_master_digit = MASTER_CODE[{w_addr, 2'b00} +: DIGIT_W];
   assign w_master_final = r_master_mis | (digit != w_master_digit);

   // Entry keeps running during lockout; only the master code can succeed then.
   assign w_accept       = enable & ~clear;
   assign w_master_clear = w_last & ~w_master_final;
   assign w_success      = w_master_clear | (w_last & ~w_alarm & ~w_final_mis);
   assign w_fail         = w_last & ~w_alarm & w_final_mis & w_master_final;

   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         r_master_mis <= 1'b0;
      end else if (w_accept) begin
         r_master_mis <= w_last ? 1'b0 : w_master_final;
      end
   end
`else
   logic w_unused_master;

   assign w_unused_master = ^MASTER_CODE;
   // Lockout freezes the walk at S_0 until reset.
   assign w_accept        = enable & ~clear & ~w_alarm;
   assign w_master_clear  = 1'b0;
   assign w_success       = w_last & ~w_final_mis;
   assign w_fail          = w_last & w_final_mis;
`endif

   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         r_state    <= S_0;
         r_mismatch <= 1'b0;
      end else if (w_accept) begin
         r_state    <= next_check_state(r_state);
         r_mismatch <= w_last ? 1'b0 : w_final_mis;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_unlocked <= 1'b0;
         r_failed   <= 1'b0;
      end else begin
         r_unlocked <= w_success;
         r_failed   <= w_fail;
      end
   end

   lockout_counter #(
      .MAX_FAILS (MAX_FAILS)
   ) u_lockout (
      .CLK         (CLK),
      .RST         (RST),
      .fail        (w_fail),
      .success     (w_success),
      .masterClear (w_master_clear),
      .failCount   (w_fail_count),
      .alarm       (w_alarm)
   );

   assign readAddress = w_addr;
   assign unlocked    = r_unlocked;
   assign failed      = r_failed;
   assign alarm       = w_alarm;
   assign failCount   = w_fail_count;
   assign dbgState    = r_state;

endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
- Reader-side counterpart to the password setter.
- Accepts a 4-digit serial entry one digit per `enable` pulse.
- Reads each stored digit from the shared 4-entry password store through a read address/data port and compares it to the entered digit.
- Reports success or failure after the 4th digit, counts consecutive failures, and latches an alarm/lockout after MAX_FAILS failures.

Parameters:
- MAX_FAILS, 3, consecutive failed entries that trigger lockout (range 1..15).
- MASTER_CODE, 16'h9999, master code, digit 0 in [3:0]; used only with MASTER_CODE_EN.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  reset: one clock; reset is synchronous and active-high.
- enable  input  1  one-cycle strobe; `digit` is valid this cycle.
- clear  input  1  abort current entry; return to digit 0.
- digit  input  4  entered digit (BCD 0-9; other values compare literally).
- readAddress  output  2  store index being checked; combinational from state.
- readData  input  4  stored digit at readAddress; combinational read, same cycle.
- unlocked  output  1  registered one-cycle pulse on correct entry.
- failed  output  1  registered one-cycle pulse on wrong entry.
- alarm  output  1  registered level; lockout active.
- failCount  output  4  consecutive-failure count.

Behaviour:
- States: S_0, S_1, S_2, S_3 (digit index). readAddress = index of current state.
- Reset (RST=1 at posedge):
  - State S_0.
  - mismatch=0, failCount=0, unlocked=0, failed=0, alarm=0.
  - Reset mid-entry discards partial entry without a failure.
- Enable handling in S_k, k<3:
  - mismatch <= mismatch | (digit != readData).
  - State advances to S_(k+1).
- Enable handling in S_3:
  - Final result = mismatch | (digit != readData).
  - State returns to S_0; mismatch cleared.
  - Result pulse appears the cycle after the 4th enable (latency 1).
- Correct entry: unlocked=1 for one cycle; failCount <= 0.
- Wrong entry:
  - failed=1 for one cycle; failCount <= failCount+1, saturating at MAX_FAILS.
  - When the new count equals MAX_FAILS, alarm <= 1 in the same cycle as the failed pulse.
- Alarm/lockout: alarm held until RST. While alarm=1, enable is ignored (state frozen at S_0), except as modified by MASTER_CODE_EN.
- clear:
  - Returns to S_0 and clears mismatch; no pulse; failCount unchanged.
  - clear and enable in the same cycle: clear wins, digit discarded.
  - clear in S_0 is a no-op.
- unlocked and failed are never both 1. Both are 0 in every cycle not following a 4th-digit enable.
- enable held high for multiple cycles counts as one digit per cycle. Debouncing is upstream.
- Store contents may change between digits; each compare uses readData in the cycle of that digit's enable.

Optional Feature:
- Macro: MASTER_CODE_EN.
- With the macro:
  - A second accumulator, masterMismatch, compares each digit with MASTER_CODE nibble k.
  - Entry succeeds if either the stored code or the master code matches.
  - A master match also clears alarm and failCount.
  - While alarm=1, entry proceeds normally, but only a master match succeeds. Any other complete entry produces no pulse and no count change.
- Without the macro: no master logic, MASTER_CODE unused, lockout exits only by RST.

Decomposition:
- Package password_pkg:
  - CheckState enum (logic [2:0]: S_0..S_3).
  - PASSWORD_LEN=4, DIGIT_W=4, ADDR_W=2.
  - The setter's SetState enum moves here too.
- One sub-module: lockout_counter. Contains failCount and alarm; inputs fail, success, masterClear; parameter MAX_FAILS.

Test Plan:
- Store 1,2,3,4; enter 1,2,3,4 → readAddress steps 0,1,2,3; unlocked=1 exactly one cycle after 4th enable; failed=0; failCount=0.
- Store 1,2,3,4; enter 1,2,3,5 → failed pulse one cycle after 4th enable; failCount=1; state back to S_0.
- Three wrong entries (MAX_FAILS=3) → failCount 1,2,3; alarm=1 with 3rd failed pulse; further enables leave readAddress=0 and produce no pulses until RST; RST → alarm=0, failCount=0.
- Enter 1,2 then clear+enable(3) same cycle → readAddress=0, no pulse, failCount unchanged; then 1,2,3,4 → unlocked.
- Two failures then correct entry → failCount returns 0; RST asserted after 2 digits → readAddress=0, outputs 0.
- MASTER_CODE_EN, MASTER_CODE=16'h9999: lock out, enter 9,9,9,9 → unlocked pulse, alarm=0, failCount=0; 1,2,3,4 while locked → no pulse.
